// File: rtl/nmi_pkg.sv
// Shared definitions for the NMI scheduler: FSM states, source indices,
// default timing parameters and counter widths.
package nmi_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    PULSE    = 3'd2,
    ACTIVE   = 3'd3,
    CLEARING = 3'd4
  } nmi_state_t;

  // Request source indices; lower index means higher priority.
  localparam int unsigned SRC_SPI = 0;
  localparam int unsigned SRC_BTN = 1;
  localparam int unsigned SRC_BRK = 2;
  localparam int unsigned SRC_DBG = 3;

  localparam int unsigned PULSE_LEN_DEF = 16;
  localparam int unsigned CLR_RFSH_DEF  = 3;

  // Counter widths cover the legal parameter ranges (1..255, 1..7).
  localparam int unsigned PCNT_W = 8;
  localparam int unsigned RCNT_W = 3;

endpackage

// File: rtl/nmi_prio_enc.sv
// Fixed-priority encoder: reports whether any request is pending and the
// lowest set index (index 0 wins).
//   i_pend : pending request bits
//   o_any  : 1 when any bit of i_pend is set
//   o_idx  : lowest set index (0 when none set)
module nmi_prio_enc #(
  parameter int unsigned NSRC = 4
) (
  input  logic [NSRC-1:0]         i_pend,
  output logic                    o_any,
  output logic [$clog2(NSRC)-1:0] o_idx
);

  localparam int unsigned IW = $clog2(NSRC);

  // Scan from the top so the lowest set index is written last.
  always_comb begin
    o_any = |i_pend;
    o_idx = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (i_pend[i]) o_idx = IW'(i);
    end
  end

endmodule

// File: rtl/nmi_sched.sv
// NMI scheduler: latches rising edges of the request sources, arbitrates by
// fixed priority, fires a fixed-length NMI pulse at frame INT start when the
// CPU is outside ROM, and tracks the in-NMI memory window until software
// clears it and the required refresh cycles have elapsed.
//   fclk, rst      : clock, synchronous active-high reset
//   zpos, rfsh_n   : Z80 clock strobe and refresh (active low)
//   req, mask      : request levels and per-source edge masks
//   int_start      : frame INT start strobe
//   last_m1_rom    : last opcode fetch came from ROM
//   clr_nmi        : software clear strobe
//   gen_nmi        : drive NMI_N low
//   in_nmi         : NMI window active
//   cause          : source index of the current NMI
//   pend           : pending request bits
module nmi_sched
  import nmi_pkg::*;
#(
  parameter int unsigned NSRC      = 4,
  parameter int unsigned PULSE_LEN = PULSE_LEN_DEF,
  parameter int unsigned CLR_RFSH  = CLR_RFSH_DEF
) (
  input  logic                    fclk,
  input  logic                    rst,
  input  logic                    zpos,
  input  logic                    rfsh_n,
  input  logic [NSRC-1:0]         req,
  input  logic [NSRC-1:0]         mask,
  input  logic                    int_start,
  input  logic                    last_m1_rom,
  input  logic                    clr_nmi,
  output logic                    gen_nmi,
  output logic                    in_nmi,
  output logic [$clog2(NSRC)-1:0] cause,
  output logic [NSRC-1:0]         pend
);

  localparam int unsigned CW = $clog2(NSRC);

  nmi_state_t        r_state;
  logic [NSRC-1:0]   r_req;
  logic [NSRC-1:0]   r_pend;
  logic [CW-1:0]     r_cause;
  logic [PCNT_W-1:0] r_pcnt;
  logic [RCNT_W-1:0] r_rcnt;
  logic              r_gen;
  logic              r_in;

  logic [NSRC-1:0]   w_rise;
  logic [NSRC-1:0]   w_clr;
  logic              w_any;
  logic [CW-1:0]     w_g;
  logic              w_grant;

  nmi_prio_enc #(.NSRC(NSRC)) u_prio (
    .i_pend (r_pend),
    .o_any  (w_any),
    .o_idx  (w_g)
  );

  assign w_rise  = req & ~r_req & ~mask;
  assign w_grant = (r_state == ARMED) && int_start && !last_m1_rom;

  // One-hot clear of the granted source; applied after the set so clear wins.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      w_clr[i] = w_grant && (w_g == CW'(i));
    end
  end

  // Edge detect, pending latch and scheduling FSM.
  always_ff @(posedge fclk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req   <= '0;
      r_pend  <= '0;
      r_cause <= '0;
      r_pcnt  <= '0;
      r_rcnt  <= '0;
      r_gen   <= 1'b0;
      r_in    <= 1'b0;
    end else begin
      r_req  <= req;
      r_pend <= (r_pend | w_rise) & ~w_clr;
      case (r_state)
        IDLE: begin
          if (w_any) r_state <= ARMED;
        end
        ARMED: begin
          // ROM-resident code defers the NMI to a later frame.
          if (w_grant) begin
            r_state <= PULSE;
            r_gen   <= 1'b1;
            r_in    <= 1'b1;
            r_cause <= w_g;
            r_pcnt  <= PCNT_W'(PULSE_LEN - 1);
          end
        end
        PULSE: begin
          if (r_pcnt == '0) begin
            r_gen   <= 1'b0;
            r_state <= ACTIVE;
          end else begin
            r_pcnt <= r_pcnt - PCNT_W'(1);
          end
        end
        ACTIVE: begin
          if (clr_nmi) begin
            r_state <= CLEARING;
            r_rcnt  <= RCNT_W'(CLR_RFSH);
          end
        end
        CLEARING: begin
          // Window stays mapped until enough refresh cycles follow the clear.
          if (clr_nmi) begin
            r_rcnt <= RCNT_W'(CLR_RFSH);
          end else if (r_rcnt == '0) begin
            r_in    <= 1'b0;
            r_state <= w_any ? ARMED : IDLE;
          end else if (zpos && !rfsh_n) begin
            r_rcnt <= r_rcnt - RCNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gen_nmi = r_gen;
  assign in_nmi  = r_in;
  assign cause   = r_cause;
  assign pend    = r_pend;

endmodule

// File: tb/tb_nmi_sched.sv
// Self-checking bench for nmi_sched: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a reference model.
module tb_nmi_sched;

  localparam int NS    = 4;
  localparam int PLEN  = 16;
  localparam int CRFSH = 3;

  logic          fclk = 1'b0;
  logic          rst = 1'b1;
  logic          zpos = 1'b0;
  logic          rfsh_n = 1'b1;
  logic [NS-1:0] req = '0;
  logic [NS-1:0] mask = '0;
  logic          int_start = 1'b0;
  logic          last_m1_rom = 1'b0;
  logic          clr_nmi = 1'b0;
  logic          gen_nmi;
  logic          in_nmi;
  logic [1:0]    cause;
  logic [NS-1:0] pend;

  int n_chk = 0;
  int n_fail = 0;

  nmi_sched dut (
    .fclk        (fclk),
    .rst         (rst),
    .zpos        (zpos),
    .rfsh_n      (rfsh_n),
    .req         (req),
    .mask        (mask),
    .int_start   (int_start),
    .last_m1_rom (last_m1_rom),
    .clr_nmi     (clr_nmi),
    .gen_nmi     (gen_nmi),
    .in_nmi      (in_nmi),
    .cause       (cause),
    .pend        (pend)
  );

  always #5 fclk = ~fclk;

  // ---------------- reference model ----------------
  // Tracks remaining pulse cycles, the window flag, remaining refresh
  // cycles (-1 when no clear is in progress) and whether an NMI is waiting
  // for a frame start.
  logic [NS-1:0] m_req = '0;
  logic [NS-1:0] m_pend = '0;
  logic [1:0]    m_cause = '0;
  int            m_pulse_left = 0;
  bit            m_window = 1'b0;
  int            m_clear_left = -1;
  bit            m_armed = 1'b0;

  always @(posedge fclk) begin
    logic [NS-1:0] np;
    int g;
    np = m_pend | (req & ~m_req & ~mask);
    if (rst) begin
      m_req = '0; m_pend = '0; m_cause = '0; m_pulse_left = 0;
      m_window = 1'b0; m_clear_left = -1; m_armed = 1'b0;
    end else begin
      m_req = req;
      if (m_armed && int_start && !last_m1_rom) begin
        g = 0;
        for (int i = NS - 1; i >= 0; i--) if (m_pend[i]) g = i;
        np[g] = 1'b0;
        m_cause = 2'(g);
        m_pulse_left = PLEN;
        m_window = 1'b1;
        m_armed = 1'b0;
      end else if (m_pulse_left > 0) begin
        m_pulse_left--;
      end else if (m_window) begin
        if (clr_nmi) m_clear_left = CRFSH;
        else if (m_clear_left == 0) begin
          m_window = 1'b0;
          m_clear_left = -1;
          m_armed = (m_pend != '0);
        end else if (m_clear_left > 0 && zpos && !rfsh_n) m_clear_left--;
      end else if (!m_armed && m_pend != '0) begin
        m_armed = 1'b1;
      end
      m_pend = np;
    end
  end

  // ---------------- helpers ----------------
  task automatic cyc();
    @(posedge fclk);
    #1;
  endtask

  task automatic strobes_off();
    int_start = 1'b0; clr_nmi = 1'b0; zpos = 1'b0; rfsh_n = 1'b1; last_m1_rom = 1'b0;
  endtask

  task automatic chk(input string nm, input logic eg, input logic ei,
                     input logic [1:0] ec, input logic [NS-1:0] ep);
    n_chk++;
    if (gen_nmi !== eg || in_nmi !== ei || cause !== ec || pend !== ep) begin
      n_fail++;
      $display("FAIL %s: got gen=%0b in=%0b cause=%0d pend=%b, expected gen=%0b in=%0b cause=%0d pend=%b",
               nm, gen_nmi, in_nmi, cause, pend, eg, ei, ec, ep);
    end
  endtask

  // From the cycle after a grant: run out the pulse, clear, count refreshes.
  task automatic finish_nmi(input string nm, input logic [1:0] c, input logic [NS-1:0] p);
    strobes_off();
    repeat (PLEN - 1) cyc();
    chk({nm, "_pulse_high"}, 1'b1, 1'b1, c, p);
    cyc();
    chk({nm, "_pulse_low"}, 1'b0, 1'b1, c, p);
    clr_nmi = 1'b1; cyc(); clr_nmi = 1'b0;
    zpos = 1'b1; rfsh_n = 1'b0;
    repeat (CRFSH) cyc();
    chk({nm, "_still_in"}, 1'b0, 1'b1, c, p);
    strobes_off();
    cyc();
    chk({nm, "_window_end"}, 1'b0, 1'b0, c, p);
  endtask

  typedef struct {
    logic [NS-1:0] req;
    logic          ist, rom, clr, zp, rf;
    int            n;
    logic          eg, ei;
    logic [1:0]    ec;
    logic [NS-1:0] ep;
    string         nm;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [NS-1:0] rq, logic ist, logic rom, logic clr,
                              logic zp, logic rf, int n, logic eg, logic ei,
                              logic [1:0] ec, logic [NS-1:0] ep, string nm);
    vec_t v;
    v.req = rq; v.ist = ist; v.rom = rom; v.clr = clr; v.zp = zp; v.rf = rf;
    v.n = n; v.eg = eg; v.ei = ei; v.ec = ec; v.ep = ep; v.nm = nm;
    return v;
  endfunction

  initial begin
    // Basic grant, clr ignored in pulse, clear timing with interleaved zpos.
    tbl.push_back(mk(4'b0100, 0,0,0,0,1,  1, 0,0,2'd0,4'b0100, "edge_sets_pend"));
    tbl.push_back(mk(4'b0100, 0,0,0,0,1,  1, 0,0,2'd0,4'b0100, "armed_wait"));
    tbl.push_back(mk(4'b0100, 1,0,0,0,1,  1, 1,1,2'd2,4'b0000, "grant_src2"));
    tbl.push_back(mk(4'b0100, 0,0,1,0,1, 15, 1,1,2'd2,4'b0000, "pulse_clr_ignored"));
    tbl.push_back(mk(4'b0100, 0,0,0,0,1,  1, 0,1,2'd2,4'b0000, "pulse_len_16"));
    tbl.push_back(mk(4'b0100, 0,0,0,0,1,  3, 0,1,2'd2,4'b0000, "active_holds"));
    tbl.push_back(mk(4'b0100, 0,0,1,0,1,  1, 0,1,2'd2,4'b0000, "clr_accepted"));
    tbl.push_back(mk(4'b0100, 0,0,0,1,0,  1, 0,1,2'd2,4'b0000, "rfsh_1"));
    tbl.push_back(mk(4'b0100, 0,0,0,1,1,  1, 0,1,2'd2,4'b0000, "zpos_no_rfsh"));
    tbl.push_back(mk(4'b0100, 0,0,0,1,0,  1, 0,1,2'd2,4'b0000, "rfsh_2"));
    tbl.push_back(mk(4'b0100, 0,0,0,1,0,  1, 0,1,2'd2,4'b0000, "rfsh_3"));
    tbl.push_back(mk(4'b0100, 0,0,0,0,1,  1, 0,0,2'd2,4'b0000, "window_ends"));
    // Priority: sources 3 and 1 rise together.
    tbl.push_back(mk(4'b1010, 0,0,0,0,1,  1, 0,0,2'd2,4'b1010, "two_rise"));
    tbl.push_back(mk(4'b1010, 0,0,0,0,1,  1, 0,0,2'd2,4'b1010, "armed_two"));
    tbl.push_back(mk(4'b1010, 1,0,0,0,1,  1, 1,1,2'd1,4'b1000, "prio_cause1"));
    tbl.push_back(mk(4'b1010, 0,0,0,0,1, 16, 0,1,2'd1,4'b1000, "pulse2_done"));
    tbl.push_back(mk(4'b1010, 0,0,1,0,1,  1, 0,1,2'd1,4'b1000, "clr2"));
    tbl.push_back(mk(4'b1010, 0,0,0,1,0,  3, 0,1,2'd1,4'b1000, "rfsh_x3"));
    tbl.push_back(mk(4'b1010, 0,0,0,0,1,  1, 0,0,2'd1,4'b1000, "clear_to_armed"));
    tbl.push_back(mk(4'b1010, 1,0,0,0,1,  1, 1,1,2'd3,4'b0000, "second_cause3"));
    tbl.push_back(mk(4'b1010, 0,0,0,0,1, 16, 0,1,2'd3,4'b0000, "pulse3_done"));
    tbl.push_back(mk(4'b1010, 0,0,1,0,1,  1, 0,1,2'd3,4'b0000, "clr3"));
    tbl.push_back(mk(4'b1010, 0,0,0,1,0,  3, 0,1,2'd3,4'b0000, "rfsh3_x3"));
    tbl.push_back(mk(4'b1010, 0,0,0,0,1,  1, 0,0,2'd3,4'b0000, "window3_ends"));
    tbl.push_back(mk(4'b0000, 0,0,0,0,1,  2, 0,0,2'd3,4'b0000, "cause_holds"));
    tbl.push_back(mk(4'b0000, 1,0,0,0,1,  1, 0,0,2'd3,4'b0000, "int_in_idle"));

    // Reset state.
    rst = 1'b1;
    cyc(); cyc();
    chk("reset_state", 1'b0, 1'b0, 2'd0, 4'b0000);
    rst = 1'b0;
    cyc();
    chk("post_reset_idle", 1'b0, 1'b0, 2'd0, 4'b0000);

    // Table-driven vectors.
    foreach (tbl[k]) begin
      req = tbl[k].req; int_start = tbl[k].ist; last_m1_rom = tbl[k].rom;
      clr_nmi = tbl[k].clr; zpos = tbl[k].zp; rfsh_n = tbl[k].rf;
      repeat (tbl[k].n) cyc();
      chk(tbl[k].nm, tbl[k].eg, tbl[k].ei, tbl[k].ec, tbl[k].ep);
    end
    strobes_off();

    // ROM deferral: two frame starts inside ROM, then one outside.
    req = 4'b0001; cyc();
    chk("rom_pend", 1'b0, 1'b0, 2'd3, 4'b0001);
    req = 4'b0000; cyc();
    int_start = 1'b1; last_m1_rom = 1'b1; cyc(); strobes_off();
    chk("rom_defer1", 1'b0, 1'b0, 2'd3, 4'b0001);
    repeat (3) cyc();
    int_start = 1'b1; last_m1_rom = 1'b1; cyc(); strobes_off();
    chk("rom_defer2", 1'b0, 1'b0, 2'd3, 4'b0001);
    int_start = 1'b1; cyc(); strobes_off();
    chk("rom_fire", 1'b1, 1'b1, 2'd0, 4'b0000);
    finish_nmi("rom", 2'd0, 4'b0000);

    // Mask blocks an edge; lifting the mask later creates no edge.
    mask = 4'b0001; req = 4'b0001; cyc();
    chk("mask_blocks", 1'b0, 1'b0, 2'd0, 4'b0000);
    mask = 4'b0000; cyc();
    int_start = 1'b1; cyc(); strobes_off();
    chk("unmask_no_edge", 1'b0, 1'b0, 2'd0, 4'b0000);
    req = 4'b0000; cyc();

    // No nesting: request during the pulse waits for the window to close.
    req = 4'b0100; cyc(); cyc();
    int_start = 1'b1; cyc();
    chk("nest_first", 1'b1, 1'b1, 2'd2, 4'b0000);
    req = 4'b0110; cyc();
    chk("nest_pend_in_pulse", 1'b1, 1'b1, 2'd2, 4'b0010);
    repeat (PLEN - 2) cyc();
    chk("nest_pulse_last", 1'b1, 1'b1, 2'd2, 4'b0010);
    cyc();
    chk("nest_pulse_end", 1'b0, 1'b1, 2'd2, 4'b0010);
    cyc();
    chk("no_nest_active", 1'b0, 1'b1, 2'd2, 4'b0010);
    strobes_off();
    clr_nmi = 1'b1; cyc(); clr_nmi = 1'b0;
    zpos = 1'b1; rfsh_n = 1'b0; repeat (CRFSH) cyc(); strobes_off();
    cyc();
    chk("nest_window_end", 1'b0, 1'b0, 2'd2, 4'b0010);
    int_start = 1'b1; cyc(); strobes_off();
    chk("nest_served", 1'b1, 1'b1, 2'd1, 4'b0000);
    finish_nmi("nest", 2'd1, 4'b0000);

    // Reset in the fifth pulse cycle with another request pending.
    req = 4'b1000; cyc(); cyc();
    int_start = 1'b1; cyc(); strobes_off();
    chk("rst_grant", 1'b1, 1'b1, 2'd3, 4'b0000);
    req = 4'b1001; cyc();
    repeat (3) cyc();
    chk("rst_pulse5", 1'b1, 1'b1, 2'd3, 4'b0001);
    rst = 1'b1; req = 4'b0000; cyc();
    chk("reset_mid_pulse", 1'b0, 1'b0, 2'd0, 4'b0000);
    rst = 1'b0; int_start = 1'b1; cyc(); cyc(); strobes_off();
    chk("after_reset_idle", 1'b0, 1'b0, 2'd0, 4'b0000);

    // Randomized traffic against the model.
    for (int c = 0; c < 6000; c++) begin
      for (int i = 0; i < NS; i++) if ($urandom_range(0, 11) == 0) req[i] = ~req[i];
      if ($urandom_range(0, 49) == 0) mask = 4'($urandom);
      int_start   = ($urandom_range(0, 9) == 0);
      last_m1_rom = ($urandom_range(0, 2) == 0);
      clr_nmi     = ($urandom_range(0, 11) == 0);
      zpos        = ($urandom_range(0, 2) == 0);
      rfsh_n      = ($urandom_range(0, 1) == 0);
      rst         = ($urandom_range(0, 999) == 0);
      cyc();
      chk("random", 1'(m_pulse_left > 0), m_window, m_cause, m_pend);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
